dwc_upconv_wchannel_packer: RTL and testbench

// - Write-data path of the AXI4 data-width up converter: packs narrow master W beats into wide slave W beats.
// - Per-burst command (addr/len/size/fixed/wrap) is queued from the AW path; packing follows the narrow address lane by lane.
// - Sits between the narrow MASTER_W* port and the wide SLAVE_W* port; counterpart of the up converter's R-channel unpacker.

---
 rtl/dwc_upconv_pkg.sv | 25 ++
 rtl/dwc_upconv_wchannel_packer_if.sv | 34 +++
 rtl/dwc_upconv_wcmd_fifo.sv | 69 ++++++
 rtl/dwc_upconv_wchannel_packer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dwc_upconv_wchannel_packer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dwc_upconv_pkg.sv
// Shared types and default geometry for the AXI4 up-converter W path.
package dwc_upconv_pkg;

  localparam int DEF_DATA_WIDTH_IN  = 32;
  localparam int DEF_DATA_WIDTH_OUT = 64;
  localparam int RATIO      = DEF_DATA_WIDTH_OUT / DEF_DATA_WIDTH_IN;
  localparam int LANE_W     = $clog2(RATIO);
  localparam int IN_BYTE_W  = $clog2(DEF_DATA_WIDTH_IN / 8);
  localparam int OUT_BYTE_W = $clog2(DEF_DATA_WIDTH_OUT / 8);

  // One queued burst as seen by the W packer
  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic       fixed;
    logic [5:0] wrap_mask;
  } cmd_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/dwc_upconv_wchannel_packer_if.sv
// Narrow (MASTER_W*) and wide (SLAVE_W*) write-data channels of the packer.
// master: environment side (narrow W source plus wide W sink); slave: the packer.
interface dwc_upconv_wchannel_packer_if #(
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_IN  = 32,
  parameter int DATA_WIDTH_OUT = 64
);
  logic [DATA_WIDTH_IN-1:0]    MASTER_WDATA;
  logic [DATA_WIDTH_IN/8-1:0]  MASTER_WSTRB;
  logic [USER_WIDTH-1:0]       MASTER_WUSER;
  logic                        MASTER_WLAST;
  logic                        MASTER_WVALID;
  logic                        MASTER_WREADY;
  logic [DATA_WIDTH_OUT-1:0]   SLAVE_WDATA;
  logic [DATA_WIDTH_OUT/8-1:0] SLAVE_WSTRB;
  logic [USER_WIDTH-1:0]       SLAVE_WUSER;
  logic                        SLAVE_WLAST;
  logic                        SLAVE_WVALID;
  logic                        SLAVE_WREADY;

  modport master (
    output MASTER_WDATA, MASTER_WSTRB, MASTER_WUSER, MASTER_WLAST, MASTER_WVALID,
    input  MASTER_WREADY,
    input  SLAVE_WDATA, SLAVE_WSTRB, SLAVE_WUSER, SLAVE_WLAST, SLAVE_WVALID,
    output SLAVE_WREADY
  );

  modport slave (
    input  MASTER_WDATA, MASTER_WSTRB, MASTER_WUSER, MASTER_WLAST, MASTER_WVALID,
    output MASTER_WREADY,
    output SLAVE_WDATA, SLAVE_WSTRB, SLAVE_WUSER, SLAVE_WLAST, SLAVE_WVALID,
    input  SLAVE_WREADY
  );
endinterface

// File: rtl/dwc_upconv_wcmd_fifo.sv
// Burst command queue: synchronous FIFO of cmd_t records.
// A push while full is dropped unless a pop frees a slot in the same cycle.
module dwc_upconv_wcmd_fifo
  import dwc_upconv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Queue state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dwc_upconv_wchannel_packer.sv
// AXI4 up-converter W path: packs narrow MASTER_W beats into wide SLAVE_W beats,
// following the narrow address lane by lane for each queued burst command.
// Build option: DWC_UPCONV_W_SKID_EN adds a 2-entry output skid buffer and a
// registered MASTER_WREADY (no combinational SLAVE_WREADY -> MASTER_WREADY path).
//
// state | meaning
// IDLE  | no burst active; pops the next command when the queue is non-empty
// ACCUM | accepting narrow beats, merging them into lanes, flushing wide beats
module dwc_upconv_wchannel_packer
  import dwc_upconv_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
  parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       cmd_wr_en,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_len,
  input  logic [2:0] cmd_size,
  input  logic       cmd_fixed,
  input  logic [5:0] cmd_wrap_mask,
  output logic       cmd_fifo_full,
  dwc_upconv_wchannel_packer_if.slave w_if,
  output logic       wlast_err
);
  localparam int IN_B     = DATA_WIDTH_IN / 8;
  localparam int OUT_B    = DATA_WIDTH_OUT / 8;
  localparam int RATIO_L  = DATA_WIDTH_OUT / DATA_WIDTH_IN;
  localparam int LANE_W_L = $clog2(RATIO_L);
  localparam int IN_BW    = $clog2(IN_B);
  localparam int OUT_BW   = $clog2(OUT_B);
  localparam logic [0:0] S_IDLE  = 1'(IDLE);
  localparam logic [0:0] S_ACCUM = 1'(ACCUM);

  // ID_WIDTH only keeps the parameter list aligned with the AW path
  if (ID_WIDTH > 0) begin : g_id_width_unused
  end

  typedef struct packed {
    logic [DATA_WIDTH_OUT-1:0] data;
    logic [OUT_B-1:0]          strb;
    logic [USER_WIDTH-1:0]     user;
    logic                      last;
  } beat_t;

  cmd_t                      cmd_in, cmd_out;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [0:0]                state_q, state_d;
  logic [5:0]                addr_q, addr_d, mask_q, mask_d;
  logic [7:0]                len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]                size_q, size_d;
  logic                      fixed_q, fixed_d;
  logic [DATA_WIDTH_OUT-1:0] acc_data_q, acc_data_d, merged_data;
  logic [OUT_B-1:0]          acc_strb_q, acc_strb_d, merged_strb;
  logic                      wlast_err_q, wlast_err_d;
  logic [LANE_W_L-1:0]       lane;
  logic [5:0]                addr_incr, addr_next;
  logic                      is_last, accept, flush, m_ready;
  beat_t                     flush_beat, out_head;
  logic                      out_valid;

  assign cmd_in = '{addr: cmd_addr, len: cmd_len, size: cmd_size,
                    fixed: cmd_fixed, wrap_mask: cmd_wrap_mask};

  dwc_upconv_wcmd_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .push      (cmd_wr_en),
    .push_data (cmd_in),
    .pop       (fifo_pop),
    .pop_data  (cmd_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign lane    = addr_q[OUT_BW-1:IN_BW];
  assign is_last = (beat_cnt_q == len_q);
  assign accept  = w_if.MASTER_WVALID && m_ready;

  // Lane merge of the current beat and next-address / flush decision
  always_comb begin
    merged_data = acc_data_q;
    merged_strb = acc_strb_q;
    for (int i = 0; i < RATIO_L; i++) begin
      if (lane == LANE_W_L'(i)) begin
        merged_data[i*DATA_WIDTH_IN +: DATA_WIDTH_IN] = w_if.MASTER_WDATA;
        merged_strb[i*IN_B +: IN_B]                   = w_if.MASTER_WSTRB;
      end
    end
    addr_incr = 6'd1 << size_q;
    addr_next = fixed_q ? addr_q
                        : ((addr_q & ~mask_q) | ((addr_q + addr_incr) & mask_q));
    // Leaving the current wide word (or a FIXED/last beat) closes the wide beat
    flush = accept && (is_last || fixed_q ||
                       ((addr_next >> OUT_BW) != (addr_q >> OUT_BW)));
    flush_beat = '{data: merged_data, strb: merged_strb,
                   user: w_if.MASTER_WUSER, last: is_last};
  end

  // Packer FSM: command load, beat counting, accumulator update
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    fixed_d     = fixed_q;
    mask_d      = mask_q;
    beat_cnt_d  = beat_cnt_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    wlast_err_d = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          addr_d     = cmd_out.addr;
          len_d      = cmd_out.len;
          size_d     = cmd_out.size;
          fixed_d    = cmd_out.fixed;
          mask_d     = cmd_out.wrap_mask;
          beat_cnt_d = 8'd0;
          state_d    = S_ACCUM;
        end
      end
      default: begin
        if (accept) begin
          addr_d      = addr_next;
          acc_data_d  = merged_data;
          acc_strb_d  = flush ? '0 : merged_strb;
          wlast_err_d = (w_if.MASTER_WLAST != is_last);
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Packer state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      fixed_q     <= 1'b0;
      mask_q      <= '0;
      beat_cnt_q  <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      fixed_q     <= fixed_d;
      mask_q      <= mask_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      wlast_err_q <= wlast_err_d;
    end
  end

`ifdef DWC_UPCONV_W_SKID_EN
  beat_t      skid_q [2];
  beat_t      skid_d [2];
  logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] skid_cnt_q, skid_cnt_d;
  logic       ready_q, ready_d, skid_pop;

  // Skid buffer: flushes write, wide handshakes read; ready looks one cycle ahead
  always_comb begin
    skid_d   = skid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    skid_pop = (skid_cnt_q != 2'd0) && w_if.SLAVE_WREADY;
    if (flush) begin
      skid_d[wr_ptr_q] = flush_beat;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (skid_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({flush, skid_pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase
    ready_d = (state_d == S_ACCUM) && (skid_cnt_d != 2'd2);
  end

  // Skid buffer registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      skid_cnt_q <= 2'd0;
      ready_q    <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skid_cnt_q <= skid_cnt_d;
      ready_q    <= ready_d;
    end
  end

  assign out_head  = skid_q[rd_ptr_q];
  assign out_valid = (skid_cnt_q != 2'd0);
  assign m_ready   = ready_q;
`else
  beat_t out_q, out_d;
  logic  out_valid_q, out_valid_d;

  // Single output register: hold until taken, reload on flush without a bubble
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && w_if.SLAVE_WREADY) begin
      out_valid_d = 1'b0;
    end
    if (flush) begin
      out_d       = flush_beat;
      out_valid_d = 1'b1;
    end
  end

  // Output register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_head  = out_q;
  assign out_valid = out_valid_q;
  assign m_ready   = (state_q == S_ACCUM) && (!out_valid_q || w_if.SLAVE_WREADY);
`endif

  assign w_if.MASTER_WREADY = m_ready;
  assign w_if.SLAVE_WDATA   = out_head.data;
  assign w_if.SLAVE_WSTRB   = out_head.strb;
  assign w_if.SLAVE_WUSER   = out_head.user;
  assign w_if.SLAVE_WLAST   = out_head.last;
  assign w_if.SLAVE_WVALID  = out_valid;
  assign cmd_fifo_full      = fifo_full;
  assign wlast_err          = wlast_err_q;

endmodule

// File: tb/tb_dwc_upconv_wchannel_packer.sv
// Directed bench for dwc_upconv_wchannel_packer (32 -> 64 bit) with a scoreboard
// of expected wide beats produced by a lane-walk model of each burst.
module tb_dwc_upconv_wchannel_packer;
  import dwc_upconv_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        user;
    logic        last;
  } wbeat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_wr_en;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size;
  logic       cmd_fixed;
  logic [5:0] cmd_wrap_mask;
  logic       cmd_fifo_full;
  logic       wlast_err;

  int errs   = 0;
  int checks = 0;

  wbeat_t      sb [$];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  logic        bu [16];
  logic        bl [16];
  logic [31:0] m_acc_d [2];
  logic [3:0]  m_acc_s [2];

  dwc_upconv_wchannel_packer_if #(.USER_WIDTH(1), .DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(64)) w_if ();

  dwc_upconv_wchannel_packer #(
    .ID_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(64), .CMD_FIFO_DEPTH(4)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .cmd_wr_en     (cmd_wr_en),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_size      (cmd_size),
    .cmd_fixed     (cmd_fixed),
    .cmd_wrap_mask (cmd_wrap_mask),
    .cmd_fifo_full (cmd_fifo_full),
    .w_if          (w_if),
    .wlast_err     (wlast_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a wide beat transfers at the posedge after this negedge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w_if.SLAVE_WVALID === 1'b1 && w_if.SLAVE_WREADY === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        wbeat_t e;
        logic [63:0] m;
        e = sb.pop_front();
        for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{e.strb[b]}};
        chk("wdata", w_if.SLAVE_WDATA & m, e.data & m);
        chk("wstrb", 64'(w_if.SLAVE_WSTRB), 64'(e.strb));
        chk("wlast", 64'(w_if.SLAVE_WLAST), 64'(e.last));
        chk("wuser", 64'(w_if.SLAVE_WUSER), 64'(e.user));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_inc(input int len, input logic [31:0] base);
    for (int i = 0; i <= len; i++) begin
      bd[i] = base + 32'(i);
      bs[i] = 4'hF;
      bu[i] = 1'(i & 1);
      bl[i] = (i == len);
    end
  endtask

  // Expected wide beats of one burst, walking the narrow address lane by lane
  task automatic model_burst(input logic [5:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic fixed, input logic [5:0] mask);
    logic [5:0]        a, na, t;
    logic [LANE_W-1:0] ln;
    wbeat_t            e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      ln = LANE_W'(a >> IN_BYTE_W);
      m_acc_d[ln] = bd[i];
      m_acc_s[ln] = bs[i];
      if (fixed) na = a;
      else begin
        t  = a + (6'd1 << size);
        na = (a & ~mask) | (t & mask);
      end
      if (i == int'(len) || fixed || (na >> OUT_BYTE_W) != (a >> OUT_BYTE_W)) begin
        e.data = {m_acc_d[1], m_acc_d[0]};
        e.strb = {m_acc_s[1], m_acc_s[0]};
        e.user = bu[i];
        e.last = (i == int'(len));
        sb.push_back(e);
        m_acc_s[0] = 4'h0;
        m_acc_s[1] = 4'h0;
      end
      a = na;
    end
  endtask

  // Called at posedge+1; returns at posedge+1
  task automatic push_cmd(input logic [5:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic fixed, input logic [5:0] mask);
    cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_fixed = fixed; cmd_wrap_mask = mask;
    cmd_wr_en = 1'b1;
    @(posedge clk); #1;
    cmd_wr_en = 1'b0;
  endtask

  task automatic drive_beat(input int i);
    int n;
    n = 0;
    w_if.MASTER_WDATA  = bd[i];
    w_if.MASTER_WSTRB  = bs[i];
    w_if.MASTER_WUSER  = bu[i];
    w_if.MASTER_WLAST  = bl[i];
    w_if.MASTER_WVALID = 1'b1;
    @(negedge clk);
    while (w_if.MASTER_WREADY !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accepted", 64'(w_if.MASTER_WREADY), 64'd1);
    @(posedge clk); #1;
    w_if.MASTER_WVALID = 1'b0;
  endtask

  task automatic run_burst(input logic [5:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic fixed, input logic [5:0] mask);
    model_burst(addr, len, size, fixed, mask);
    push_cmd(addr, len, size, fixed, mask);
    for (int i = 0; i <= int'(len); i++) drive_beat(i);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || w_if.SLAVE_WVALID === 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_wr_en = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_fixed = 1'b0; cmd_wrap_mask = '0;
    w_if.MASTER_WDATA = '0; w_if.MASTER_WSTRB = '0; w_if.MASTER_WUSER = '0;
    w_if.MASTER_WLAST = 1'b0; w_if.MASTER_WVALID = 1'b0; w_if.SLAVE_WREADY = 1'b0;
    m_acc_d[0] = '0; m_acc_d[1] = '0; m_acc_s[0] = '0; m_acc_s[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_swvalid", 64'(w_if.SLAVE_WVALID), 64'd0);
    chk("rst_swdata",  w_if.SLAVE_WDATA, 64'd0);
    chk("rst_mwready", 64'(w_if.MASTER_WREADY), 64'd0);
    chk("rst_full",    64'(cmd_fifo_full), 64'd0);
    chk("rst_wlasterr", 64'(wlast_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    w_if.SLAVE_WREADY = 1'b1;

    // aligned INCR, full-width beats
    fill_inc(3, 32'd1);
    run_burst(6'h00, 8'd3, 3'd2, 1'b0, 6'h3F);
    wait_drain("aligned");

    // unaligned start in the upper lane
    fill_inc(2, 32'd1);
    run_burst(6'h04, 8'd2, 3'd2, 1'b0, 6'h3F);
    wait_drain("unaligned");

    // 2-byte beats, all four land in one wide word
    fill_inc(3, 32'd0);
    bd[0] = 32'h0000_1111; bs[0] = 4'h3;
    bd[1] = 32'h2222_0000; bs[1] = 4'hC;
    bd[2] = 32'h0000_3333; bs[2] = 4'h3;
    bd[3] = 32'h4444_0000; bs[3] = 4'hC;
    run_burst(6'h00, 8'd3, 3'd1, 1'b0, 6'h3F);
    wait_drain("narrow");

    // FIXED burst: every beat flushes in the upper lane
    fill_inc(1, 32'h5);
    run_burst(6'h04, 8'd1, 3'd2, 1'b1, 6'h3F);
    wait_drain("fixed");

    // WRAP 16 bytes from 0x8 with wide-side backpressure
    fill_inc(3, 32'd1);
    model_burst(6'h08, 8'd3, 3'd2, 1'b0, 6'h0F);
    w_if.SLAVE_WREADY = 1'b0;
    push_cmd(6'h08, 8'd3, 3'd2, 1'b0, 6'h0F);
    drive_beat(0);
    drive_beat(1);
    w_if.MASTER_WDATA = bd[2]; w_if.MASTER_WSTRB = bs[2]; w_if.MASTER_WUSER = bu[2];
    w_if.MASTER_WLAST = bl[2]; w_if.MASTER_WVALID = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid",  64'(w_if.SLAVE_WVALID), 64'd1);
      chk("hold_data",   w_if.SLAVE_WDATA, 64'h0000_0002_0000_0001);
      chk("hold_mready", 64'(w_if.MASTER_WREADY), 64'd0);
    end
    @(posedge clk); #1;
    w_if.SLAVE_WREADY = 1'b1;
    drive_beat(2);
    drive_beat(3);
    wait_drain("wrap");

    // early MASTER_WLAST on beat 1 of a 4-beat burst
    fill_inc(3, 32'h10);
    bl[0] = 1'b0; bl[1] = 1'b1; bl[2] = 1'b0; bl[3] = 1'b1;
    model_burst(6'h00, 8'd3, 3'd2, 1'b0, 6'h3F);
    push_cmd(6'h00, 8'd3, 3'd2, 1'b0, 6'h3F);
    drive_beat(0);
    chk("wlast_err_b0", 64'(wlast_err), 64'd0);
    drive_beat(1);
    chk("wlast_err_b1", 64'(wlast_err), 64'd1);
    drive_beat(2);
    chk("wlast_err_b2", 64'(wlast_err), 64'd0);
    drive_beat(3);
    chk("wlast_err_b3", 64'(wlast_err), 64'd0);
    wait_drain("wlast");

    // fill the command queue, then reset in the middle of a burst
    w_if.SLAVE_WREADY = 1'b0;
    fill_inc(3, 32'h20);
    push_cmd(6'h00, 8'd3, 3'd2, 1'b0, 6'h3F);
    for (int k = 0; k < 4; k++) push_cmd(6'h00, 8'd0, 3'd2, 1'b0, 6'h3F);
    chk("fifo_full", 64'(cmd_fifo_full), 64'd1);
    push_cmd(6'h00, 8'd0, 3'd2, 1'b0, 6'h3F);
    chk("fifo_full_after_drop", 64'(cmd_fifo_full), 64'd1);
    drive_beat(0);
    drive_beat(1);
    chk("pre_reset_valid", 64'(w_if.SLAVE_WVALID), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_swvalid", 64'(w_if.SLAVE_WVALID), 64'd0);
    chk("mid_rst_swdata",  w_if.SLAVE_WDATA, 64'd0);
    chk("mid_rst_swstrb",  64'(w_if.SLAVE_WSTRB), 64'd0);
    chk("mid_rst_swlast",  64'(w_if.SLAVE_WLAST), 64'd0);
    chk("mid_rst_mwready", 64'(w_if.MASTER_WREADY), 64'd0);
    chk("mid_rst_full",    64'(cmd_fifo_full), 64'd0);
    sb.delete();
    m_acc_s[0] = '0; m_acc_s[1] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    w_if.SLAVE_WREADY = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_queue_empty", 64'(w_if.MASTER_WREADY), 64'd0);
    chk("post_rst_swvalid",     64'(w_if.SLAVE_WVALID), 64'd0);

    // recovery burst after reset
    fill_inc(3, 32'h30);
    run_burst(6'h00, 8'd3, 3'd2, 1'b0, 6'h3F);
    wait_drain("recovery");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
